// File: rtl/mfcc_pkg.sv
// Shared types and Q15 helpers for the overlap-add reconstruction datapath.
package mfcc_pkg;

    localparam logic signed [31:0] Q15_MAX = 32'sd32767;
    localparam logic signed [31:0] Q15_MIN = -32'sd32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_FLUSH
    } ola_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > Q15_MAX)
            return 16'sh7fff;
        else if (v < Q15_MIN)
            return 16'sh8000;
        return v[15:0];
    endfunction

endpackage

// File: rtl/ola_acc_mem.sv
// Accumulator register file: one read-modify-write (add) port and one read-clear port.
module ola_acc_mem #(
    parameter int DEPTH = 256,
    parameter int ACC_W = 20,
    parameter int AW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rmw_en,
    input  logic [AW-1:0]           rmw_addr,
    input  logic signed [ACC_W-1:0] rmw_data,
    input  logic [AW-1:0]           rc_addr,
    input  logic                    rc_clr,
    output logic signed [ACC_W-1:0] rc_data
);

    logic signed [ACC_W-1:0] acc [DEPTH];

    assign rc_data = acc[rc_addr];

    // The FSM never adds and clears in the same cycle; clear wins regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                acc[i] <= '0;
        end else if (rc_clr) begin
            acc[rc_addr] <= '0;
        end else if (rmw_en) begin
            acc[rmw_addr] <= acc[rmw_addr] + rmw_data;
        end
    end

endmodule

// File: rtl/overlap_add.sv
// Overlap-add frame reconstruction: accumulates windowed frames and streams out one hop per frame.
// state | meaning
// IDLE  | waiting for first sample of a frame (or a flush request)
// ACCUM | adding remaining frame samples into the accumulator
// DRAIN | emitting and clearing hop completed samples
// FLUSH | emitting and clearing the residual (size-hop) tail
module overlap_add
    import mfcc_pkg::*;
#(
    parameter int MAX_FRAME = 256,
    parameter int ACC_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] frame_in,
    input  logic        frame_in_valid,
    output logic        frame_in_ready,
    input  logic [7:0]  frame_size,
    input  logic [7:0]  frame_hop,
    input  logic        flush,
    output logic [15:0] sample_out,
    output logic        sample_out_valid,
    input  logic        sample_out_ready,
    output logic        busy,
    output logic        cfg_err
);

    localparam int AW = $clog2(MAX_FRAME);

    ola_state_t state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [7:0]    k_q, k_d, drn_q, drn_d;
    logic [7:0]    size_q, size_d, hop_q, hop_d;
    logic          pend_q, pend_d, cfg_err_q, cfg_err_d, rdy_en_q;

    logic                    rmw_en, rc_clr, in_xfer, out_xfer, cfg_bad;
    logic [AW-1:0]           rmw_addr, rc_addr;
    logic signed [ACC_W-1:0] rmw_data, rc_data;
    logic [7:0]              tail, size_lat, hop_lat;

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [7:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + (AW+1)'(b);
        if (s >= (AW+1)'(MAX_FRAME))
            s = s - (AW+1)'(MAX_FRAME);
        return s[AW-1:0];
    endfunction

    assign cfg_bad  = (frame_size < 8'd2) || (frame_hop == 8'd0) || (frame_hop > frame_size);
    assign size_lat = (frame_size < 8'd2) ? 8'd2 : frame_size;
    assign hop_lat  = cfg_bad ? size_lat : frame_hop;
    assign tail     = size_q - hop_q;

    assign frame_in_ready   = rdy_en_q && (state_q == ST_IDLE || state_q == ST_ACCUM);
    assign sample_out_valid = (state_q == ST_DRAIN) || (state_q == ST_FLUSH && tail != 8'd0);
    assign in_xfer          = frame_in_valid && frame_in_ready;
    assign out_xfer         = sample_out_valid && sample_out_ready;

    // k stays 0 outside a frame, so the same address serves the first sample in IDLE.
    assign rmw_addr   = wrap_add(base_q, k_q);
    assign rmw_data   = ACC_W'($signed(frame_in));
    assign rc_addr    = wrap_add(base_q, drn_q);
    assign sample_out = sample_out_valid ? sat16(32'(rc_data)) : 16'd0;
    assign busy       = (state_q != ST_IDLE);
    assign cfg_err    = cfg_err_q;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        k_d       = k_q;
        drn_d     = drn_q;
        size_d    = size_q;
        hop_d     = hop_q;
        pend_d    = pend_q;
        cfg_err_d = cfg_err_q;
        rmw_en    = 1'b0;
        rc_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    size_d    = size_lat;
                    hop_d     = hop_lat;
                    cfg_err_d = cfg_bad;
                    rmw_en    = 1'b1;
                    k_d       = 8'd1;
                    pend_d    = pend_q | flush;
                    state_d   = ST_ACCUM;
                end else if (flush) begin
                    drn_d   = 8'd0;
                    state_d = ST_FLUSH;
                end
            end
            ST_ACCUM: begin
                if (flush)
                    pend_d = 1'b1;
                if (in_xfer) begin
                    rmw_en = 1'b1;
                    if (k_q == size_q - 8'd1) begin
                        drn_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (flush)
                    pend_d = 1'b1;
                if (out_xfer) begin
                    rc_clr = 1'b1;
                    if (drn_q == hop_q - 8'd1) begin
                        base_d  = wrap_add(base_q, hop_q);
                        drn_d   = 8'd0;
                        k_d     = 8'd0;
                        state_d = (pend_q || flush) ? ST_FLUSH : ST_IDLE;
                    end else begin
                        drn_d = drn_q + 8'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (tail == 8'd0 || (out_xfer && drn_q == tail - 8'd1)) begin
                    rc_clr  = out_xfer;
                    base_d  = '0;
                    drn_d   = 8'd0;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (out_xfer) begin
                    rc_clr = 1'b1;
                    drn_d  = drn_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            k_q       <= '0;
            drn_q     <= '0;
            size_q    <= '0;
            hop_q     <= '0;
            pend_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            k_q       <= k_d;
            drn_q     <= drn_d;
            size_q    <= size_d;
            hop_q     <= hop_d;
            pend_q    <= pend_d;
            cfg_err_q <= cfg_err_d;
            rdy_en_q  <= 1'b1;
        end
    end

    ola_acc_mem #(
        .DEPTH (MAX_FRAME),
        .ACC_W (ACC_W),
        .AW    (AW)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .rmw_en   (rmw_en),
        .rmw_addr (rmw_addr),
        .rmw_data (rmw_data),
        .rc_addr  (rc_addr),
        .rc_clr   (rc_clr),
        .rc_data  (rc_data)
    );

endmodule

// File: tb/tb_overlap_add.sv
// Self-checking bench for overlap_add against an array-based overlap-add reference model.
module tb_overlap_add;

    localparam int MF = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] frame_in;
    logic        frame_in_valid;
    logic        frame_in_ready;
    logic [7:0]  frame_size;
    logic [7:0]  frame_hop;
    logic        flush;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready;
    logic        busy;
    logic        cfg_err;

    always #5 clk = ~clk;

    overlap_add dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_in         (frame_in),
        .frame_in_valid   (frame_in_valid),
        .frame_in_ready   (frame_in_ready),
        .frame_size       (frame_size),
        .frame_hop        (frame_hop),
        .flush            (flush),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .sample_out_ready (sample_out_ready),
        .busy             (busy),
        .cfg_err          (cfg_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          m_acc [MF];
    int          m_base, m_size, m_hop;
    int          exp_q [$];
    logic [15:0] got_q [$];
    bit          timeout;

    // ---------------- reference model ----------------
    function automatic int sat(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MF; i++) m_acc[i] = 0;
        m_base = 0; m_size = 0; m_hop = 0;
        exp_q.delete();
    endfunction

    function automatic void model_frame(int size, int hop, int s[$]);
        int es, eh;
        es = (size < 2) ? 2 : size;
        eh = (size < 2 || hop == 0 || hop > size) ? es : hop;
        m_size = es; m_hop = eh;
        for (int i = 0; i < es; i++) m_acc[(m_base + i) % MF] += s[i];
        for (int j = 0; j < eh; j++) begin
            exp_q.push_back(sat(m_acc[(m_base + j) % MF]));
            m_acc[(m_base + j) % MF] = 0;
        end
        m_base = (m_base + eh) % MF;
    endfunction

    function automatic void model_flush();
        for (int j = 0; j < m_size - m_hop; j++) begin
            exp_q.push_back(sat(m_acc[(m_base + j) % MF]));
            m_acc[(m_base + j) % MF] = 0;
        end
        m_base = 0;
    endfunction

    // ---------------- drivers (tasks start and end at a falling edge) ----------------
    task automatic send_frame(int size, int hop, int s[$], int flush_at);
        int w;
        frame_size = 8'(size);
        frame_hop  = 8'(hop);
        for (int i = 0; i < s.size(); i++) begin
            frame_in       = 16'(s[i]);
            frame_in_valid = 1'b1;
            flush          = (i == flush_at);
            w = 0;
            while (!frame_in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) timeout = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        frame_in_valid = 1'b0;
    endtask

    task automatic drain(bit stall);
        int cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 3000) begin
            sample_out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sample_out_valid && sample_out_ready) got_q.push_back(sample_out);
            @(negedge clk);
            cyc++;
        end
        sample_out_ready = 1'b0;
        if (cyc >= 3000) timeout = 1'b1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        frame_in = '0; frame_in_valid = 1'b0; flush = 1'b0; sample_out_ready = 1'b0;
        frame_size = 8'd4; frame_hop = 8'd2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    function automatic void rand_frame(int n, output int s[$]);
        s.delete();
        for (int i = 0; i < n; i++) s.push_back(int'($urandom_range(0, 65535)) - 32768);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        frame_in = '0; frame_in_valid = 1'b0; flush = 1'b0; sample_out_ready = 1'b1;
        frame_size = 8'd4; frame_hop = 8'd2;
        @(negedge clk);
        n_checks++;
        if ({sample_out, sample_out_valid, frame_in_ready, busy, cfg_err} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got out=%h v=%b rdy=%b busy=%b err=%b required all zero",
                     sample_out, sample_out_valid, frame_in_ready, busy, cfg_err);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (frame_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_clock got %b required 0", frame_in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (frame_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_release got %b required 1", frame_in_ready);
        end
        sample_out_ready = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_flush();
        int seen_valid = 0;
        sample_out_ready = 1'b1;
        pulse_flush();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL idle_flush_busy got %b required 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (sample_out_valid) seen_valid++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || seen_valid != 0) begin
            n_fail++; $display("FAIL idle_flush_return busy=%b valid_cycles=%0d required 0 and 0", busy, seen_valid);
        end
        sample_out_ready = 1'b0;
    endtask

    task automatic test_basic();
        int s[$];
        got_q.delete(); timeout = 1'b0;
        s = '{100, 200, 300, 400};
        n_checks++;
        if (sample_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid got %b required 0", sample_out_valid);
        end
        send_frame(4, 2, s, -1);
        model_frame(4, 2, s);
        n_checks++;
        if (sample_out_valid !== 1'b1 || frame_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_latency got valid=%b ready=%b required 1 and 0", sample_out_valid, frame_in_ready);
        end
        drain(1'b0);
        s = '{10, 20, 30, 40};
        send_frame(4, 2, s, -1);
        model_frame(4, 2, s);
        drain(1'b0);
        pulse_flush();
        model_flush();
        drain(1'b0);
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL basic_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_saturation();
        int s[$];
        got_q.delete(); timeout = 1'b0;
        for (int f = 0; f < 4; f++) begin
            s = (f < 2) ? '{30000, 30000, 30000, 30000} : '{-30000, -30000, -30000, -30000};
            send_frame(4, 2, s, -1);
            model_frame(4, 2, s);
            drain(1'b1);
            if (f == 1 || f == 3) begin
                pulse_flush();
                model_flush();
                drain(1'b1);
            end
        end
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL sat_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL sat_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int s[$];
        logic [15:0] held;
        got_q.delete(); timeout = 1'b0;
        rand_frame(6, s);
        send_frame(6, 4, s, -1);
        model_frame(6, 4, s);
        sample_out_ready = 1'b1;
        if (sample_out_valid) got_q.push_back(sample_out);
        @(negedge clk);
        sample_out_ready = 1'b0;
        held = sample_out;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (sample_out !== held || sample_out_valid !== 1'b1 || frame_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d got out=%h v=%b rdy=%b required out=%h v=1 rdy=0",
                         c, sample_out, sample_out_valid, frame_in_ready, held);
            end
        end
        drain(1'b0);
        pulse_flush();
        model_flush();
        drain(1'b1);
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL stall_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_cfg_err();
        int s[$];
        got_q.delete(); timeout = 1'b0;
        s = '{1, 2, 3, 4};
        send_frame(4, 0, s, -1);
        model_frame(4, 0, s);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL cfg_err_set got %b required 1", cfg_err);
        end
        drain(1'b0);
        s = '{7, 8, 9, 10};
        send_frame(4, 4, s, -1);
        model_frame(4, 4, s);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_clear got %b required 0", cfg_err);
        end
        drain(1'b0);
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL cfg_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL cfg_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        int s[$];
        int extra = 0;
        got_q.delete(); timeout = 1'b0;
        s.delete();
        for (int i = 0; i < 200; i++) s.push_back(1000);
        for (int f = 0; f < 6; f++) begin
            send_frame(200, 100, s, (f == 5) ? 50 : -1);
            model_frame(200, 100, s);
            if (f == 5) model_flush();
            drain(f[0]);
        end
        sample_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (sample_out_valid) extra++;
            @(negedge clk);
        end
        sample_out_ready = 1'b0;
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout || extra != 0) begin
            n_fail++;
            $display("FAIL wrap_count got %0d extra %0d required %0d extra 0", got_q.size(), extra, exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL wrap_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int s[$];
        int sz, hp;
        got_q.delete(); timeout = 1'b0;
        for (int f = 0; f < 10; f++) begin
            sz = $urandom_range(2, 12);
            hp = $urandom_range(1, sz);
            rand_frame(sz, s);
            send_frame(sz, hp, s, -1);
            model_frame(sz, hp, s);
            drain(1'b1);
        end
        pulse_flush();
        model_flush();
        drain(1'b1);
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL rand_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        int s[$];
        got_q.delete(); timeout = 1'b0;
        s = '{1000, 1000, 1000, 1000};
        send_frame(4, 2, s, -1);
        sample_out_ready = 1'b1;
        @(negedge clk);
        sample_out_ready = 1'b0;
        apply_reset();
        n_checks++;
        if (busy !== 1'b0 || sample_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state got busy=%b v=%b required 0 and 0", busy, sample_out_valid);
        end
        s = '{5, 6, 7, 8};
        send_frame(4, 4, s, -1);
        model_frame(4, 4, s);
        drain(1'b0);
        n_checks++;
        if (got_q.size() != exp_q.size() || timeout) begin
            n_fail++; $display("FAIL rst_mid_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== 16'(exp_q[i])) begin
                n_fail++; $display("FAIL rst_mid_out[%0d] got %0d required %0d", i, $signed(got_q[i]), exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_idle_flush();
        test_basic();
        test_saturation();
        test_backpressure();
        test_cfg_err();
        test_wrap();
        test_random();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/overlap_add.md
OVERLAP_ADD -- requirements
Module: overlap_add

Interface
REQ-001 SHALL have parameter MAX_FRAME, default 256, meaning the accumulator depth and the modulus of every buffer index.
REQ-002 SHALL have parameter ACC_W, default 20, meaning the signed accumulator entry width.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_in, input, 16 bits: signed Q15 windowed frame sample.
REQ-006 SHALL have port frame_in_valid, input, 1 bit: frame_in is valid.
REQ-007 SHALL have port frame_in_ready, output, 1 bit: block accepts frame_in.
REQ-008 SHALL have port frame_size, input, 8 bits: samples per frame, legal range 2..255.
REQ-009 SHALL have port frame_hop, input, 8 bits: hop between frames, legal range 1..frame_size.
REQ-010 SHALL have port flush, input, 1 bit: one-cycle pulse requesting emission of the residual tail.
REQ-011 SHALL have port sample_out, output, 16 bits: signed Q15 reconstructed sample.
REQ-012 SHALL have port sample_out_valid, output, 1 bit: sample_out is valid.
REQ-013 SHALL have port sample_out_ready, input, 1 bit: downstream accepts sample_out.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port cfg_err, output, 1 bit: the latched configuration was illegal.

Function
REQ-016 SHALL run an FSM with states IDLE, ACCUM, DRAIN and FLUSH; a transfer occurs on valid&&ready.
REQ-017 IDLE: frame_in_ready=1; flush goes to FLUSH; the first accepted sample latches frame_size/frame_hop, adds into acc[base], sets k=1 and goes to ACCUM.
REQ-018 Illegal config (size<2, hop==0, or hop>size) SHALL set cfg_err=1 until the next legal latch; hop is then treated as size, and size<2 as 2.
REQ-019 ACCUM: frame_in_ready=1; each transfer SHALL do acc[(base+k) mod MAX_FRAME] += sign-extended frame_in, then k++.
REQ-020 The transfer with k==size-1 SHALL go to DRAIN with d=0.
REQ-021 DRAIN: frame_in_ready=0; sample_out_valid=1; sample_out=sat16(acc[(base+d) mod MAX_FRAME]).
REQ-022 Each DRAIN output transfer SHALL zero that acc entry and increment d.
REQ-023 The DRAIN transfer with d==hop-1 SHALL set base=(base+hop) mod MAX_FRAME, then go to FLUSH if flush is pending, else IDLE.
REQ-024 A flush pulse in ACCUM or DRAIN SHALL set flush_pending; a pulse in FLUSH is ignored.
REQ-025 FLUSH: frame_in_ready=0; emits (size-hop) entries from base, clearing each; then base=0, flush_pending=0, go to IDLE.
REQ-026 A flush pulse in IDLE before any frame SHALL emit nothing and return to IDLE on the next cycle.
REQ-027 sat16: values >32767 SHALL give 32767 and values <-32768 SHALL give -32768; accumulation itself is unsaturated at ACC_W.
REQ-028 Latency: the first DRAIN sample_out_valid SHALL rise the cycle after the last frame sample transfer.
REQ-029 While sample_out_valid=1 and sample_out_ready=0, sample_out SHALL hold stable.
REQ-030 sample_out_valid SHALL be 0 in IDLE and ACCUM.
REQ-031 Index arithmetic SHALL wrap modulo MAX_FRAME with no bubble at wrap.

Reset
REQ-032 On rst_n low: state=IDLE, base=0, k=d=0, flush_pending=0, all acc entries=0.
REQ-033 On rst_n low: sample_out=0, sample_out_valid=0, frame_in_ready=0, busy=0, cfg_err=0.
REQ-034 frame_in_ready SHALL go to 1 on the first clock after release.
REQ-035 Reset mid-frame SHALL discard all partial sums.

Structure
REQ-036 Shared package mfcc_pkg SHALL hold the Q15 max/min constants, the sat16 function and the FSM state typedef.
REQ-037 Accumulator storage SHALL be sub-module ola_acc_mem: MAX_FRAME x ACC_W registers with async clear, one read-modify-write port and one read-clear port.

Verification
REQ-038 size=4, hop=2; frame [100,200,300,400] -> out 100,200; frame [10,20,30,40] -> out 310,420; flush -> out 30,40.
REQ-039 size=4, hop=2; two frames of all 30000 -> out 30000,30000, then 32767,32767 (saturation).
REQ-040 sample_out_ready low for 3 cycles mid-DRAIN -> sample_out stable, frame_in_ready=0, no sample lost or duplicated.
REQ-041 size=4, hop=0 -> cfg_err=1; frame [1,2,3,4] -> out 1,2,3,4.
REQ-042 rst_n pulsed mid-DRAIN, then size=4, hop=4, frame [5,6,7,8] -> out 5,6,7,8 (acc cleared).
REQ-043 size=200, hop=100, six frames of constant 1000 -> base wraps past 255; outputs 1000 for the first hop, then 2000 steady.
